system_ctrl: RTL and testbench
==============================

Name: system_ctrl

Overview:
- Second-generation system command block. It sits on the command dispatcher bus beside the other command units.
- Serves GET_VERSION with a parametrised list of info words. Serves SYNC_TIME and GET_TIME with configurable latch-synchroniser depth.
- Aggregates NFAULT sticky fault sources into an involuntary shutdown report.
- Adds a CLEAR_FAULT command that releases shutdown.

Parameters:
- CMD_BITS, 8: command code width
- CMD_GET_VERSION, 0 / CMD_SYNC_TIME, 1 / CMD_GET_TIME, 2 / CMD_SHUTDOWN, 3 / CMD_CLEAR_FAULT, 4: command codes
- RSP_GET_VERSION, 0 / RSP_GET_TIME, 1 / RSP_SHUTDOWN, 2: response codes
- VERSION, 2: first word of the version reply
- NINFO, 2: number of info words following VERSION, range 1..8
- INFO_WORDS, 0: NINFO*32-bit packed info; word i is [32*i+31:32*i], sent i=0 first
- NFAULT, 8: number of fault inputs, range 1..32
- SYNC_STAGES, 2: flops in the timesync_latch_in synchroniser, minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- systime  in  32  current system time, low word
- arg_data  in  32  current argument word
- arg_advance  out  1  held at 1; one argument is consumed per clock
- cmd  in  CMD_BITS  command code
- cmd_ready  in  1  command valid
- cmd_done  out  1  one-cycle pulse; command or report finished
- param_data  out  32  response word / response code
- param_write  out  1  param_data is a valid response word
- invol_req  out  1  request for an unsolicited report slot
- invol_grant  in  1  report slot granted
- time_in  in  64  current 64-bit time
- time_out  out  64  new time value
- time_out_en  out  1  one-cycle load strobe for time_out
- timesync_latch_in  in  1  asynchronous sync pulse
- shutdown  out  1  sticky shutdown flag
- fault_in  in  NFAULT  fault sources, level or pulse

Behaviour:
- Reset, all synchronous on rst=1:
  - All outputs 0 except arg_advance=1.
  - state=IDLE; latched_time, synchroniser, fault_vec and temp registers cleared.
  - Any operation in flight is aborted with no cmd_done.
- States: IDLE, VER, SYNC, TIME_HI, TIME_RSP, WAIT_GRANT, SHUT_TIME, SHUT_RSP. 3-bit encoding; info_idx counter is clog2(NINFO+1) bits.
- fault_vec:
  - Update every cycle: fault_vec <= fault_vec | fault_in.
  - reported flag is set once a report is sent.
- IDLE priority:
  1. Pending fault: fault_vec!=0, reported=0, shutdown=0 -> invol_req=1, go to WAIT_GRANT. cmd_ready stays pending.
  2. Otherwise, cmd_ready with a known cmd is accepted.
  3. Unknown codes are ignored.
- GET_VERSION:
  - Accept cycle: param_data=VERSION, param_write=1.
  - Next NINFO cycles: INFO word 0..NINFO-1.
  - Final cycle: param_write=0, param_data=RSP_GET_VERSION, cmd_done=1.
  - Total NINFO+2 cycles.
- SYNC_TIME:
  - Accept cycle: capture arg_data as the low word.
  - Next cycle: arg_data is the high word.
  - time_out = time_in - latched_time + {hi,lo} + SYNC_STAGES + 2, modulo 2^64.
  - time_out_en=1 and cmd_done=1 in the same cycle; clear the latched flag; return to IDLE.
- Time latch:
  - latched_time <= time_in on the falling edge of the synchronised latch, i.e. sync output 0 and previous 1.
  - This is independent of state. A simultaneous falling edge during SYNC computation uses the old latched_time.
- GET_TIME:
  - Accept cycle: param_data=time_in[31:0], param_write=1; capture time_in[63:32].
  - Next cycle: high word.
  - Next cycle: RSP_GET_TIME with cmd_done=1, param_write=0.
- SHUTDOWN command: shutdown=1 and cmd_done=1 on the accept cycle; no report.
- CLEAR_FAULT command:
  - On the accept cycle: fault_vec, reported and shutdown -> 0; cmd_done=1.
  - If fault_in is nonzero in that cycle, fault_vec takes fault_in, i.e. the clear loses to a live fault; a new report follows.
- Involuntary report:
  - On invol_grant in WAIT_GRANT: invol_req=0, param_write=1, param_data = fault_vec zero-extended to 32 bits.
  - SHUT_TIME: param_data=systime.
  - SHUT_RSP: param_write=0, param_data=RSP_SHUTDOWN, cmd_done=1, shutdown=1, reported=1.
  - Faults arriving after the report accumulate in fault_vec but are not reported until CLEAR_FAULT.
- invol_req is held until invol_grant; a grant outside WAIT_GRANT is ignored.
- cmd_done and time_out_en are one-cycle pulses; never asserted back-to-back for one command.

Decomposition:
- Shared package holds the command/response code defaults and the state encoding constants.
- One sub-module, sync_falling_edge: parametrised by SYNC_STAGES; outputs a single-cycle falling-edge pulse from the asynchronous input.

Test Plan:
- GET_VERSION, NINFO=2, INFO_WORDS={32'h0000_0010, 32'h0403_0201}:
  - param_data 2, 0x04030201, 0x00000010 with param_write=1 on three consecutive cycles.
  - Then RSP 0 with cmd_done=1.
- SYNC_TIME:
  - Stimulus: latch falling edge while time_in=1000; later time_in=1500; args lo=0x10, hi=0.
  - time_out = 1500-1000+16+4 = 520; time_out_en and cmd_done pulsed together.
- GET_TIME at time_in=64'h0000_0005_0000_0007 -> words 7, then 5, then RSP 1.
- Fault report:
  - Stimulus: fault_in[3] pulses for 1 cycle; grant after 5 cycles.
  - Report words 0x8, then systime, then RSP 2; shutdown=1.
  - A second fault produces no new invol_req.
- CLEAR_FAULT:
  - With fault_in[0] held high: shutdown clears, then a new report 0x1 is issued.
  - With fault_in low: stays clear.
- Priority: fault and cmd_ready=GET_TIME in the same cycle -> report completes first, then the GET_TIME reply.
- Reset asserted mid-GET_VERSION -> param_write=0 next cycle, no cmd_done; a fresh command then works.

Source files
------------

// File: rtl/system_ctrl_pkg.sv
// Shared definitions for the system command block.
// Holds the default command/response codes and the controller state encoding.
package system_ctrl_pkg;

    localparam int DEF_CMD_GET_VERSION = 0;
    localparam int DEF_CMD_SYNC_TIME   = 1;
    localparam int DEF_CMD_GET_TIME    = 2;
    localparam int DEF_CMD_SHUTDOWN    = 3;
    localparam int DEF_CMD_CLEAR_FAULT = 4;

    localparam int DEF_RSP_GET_VERSION = 0;
    localparam int DEF_RSP_GET_TIME    = 1;
    localparam int DEF_RSP_SHUTDOWN    = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VER        = 3'd1,
        ST_SYNC       = 3'd2,
        ST_TIME_HI    = 3'd3,
        ST_TIME_RSP   = 3'd4,
        ST_WAIT_GRANT = 3'd5,
        ST_SHUT_TIME  = 3'd6,
        ST_SHUT_RSP   = 3'd7
    } state_t;

endpackage

// File: rtl/system_ctrl_sync_falling_edge.sv
// Synchroniser for an asynchronous pulse plus falling-edge detector.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   i_async - asynchronous input
//   o_fall  - one-cycle pulse when the synchronised input goes 1 -> 0
module sync_falling_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/system_ctrl.sv
// System command block: version query, time sync/query, fault aggregation with
// unsolicited shutdown report, explicit shutdown and fault clear.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cmd, cmd_ready, cmd_done      - command code/valid in, completion pulse out
//   arg_data, arg_advance         - argument stream (one word per clock)
//   param_data, param_write       - response word stream
//   invol_req, invol_grant        - unsolicited report slot handshake
//   systime, time_in              - current time (32-bit low word / 64-bit)
//   time_out, time_out_en         - new time value and load strobe
//   timesync_latch_in             - asynchronous time-latch pulse
//   shutdown                      - sticky shutdown flag
//   fault_in                      - fault sources
module system_ctrl
    import system_ctrl_pkg::*;
#(
    parameter int                  CMD_BITS        = 8,
    parameter int                  CMD_GET_VERSION = DEF_CMD_GET_VERSION,
    parameter int                  CMD_SYNC_TIME   = DEF_CMD_SYNC_TIME,
    parameter int                  CMD_GET_TIME    = DEF_CMD_GET_TIME,
    parameter int                  CMD_SHUTDOWN    = DEF_CMD_SHUTDOWN,
    parameter int                  CMD_CLEAR_FAULT = DEF_CMD_CLEAR_FAULT,
    parameter int                  RSP_GET_VERSION = DEF_RSP_GET_VERSION,
    parameter int                  RSP_GET_TIME    = DEF_RSP_GET_TIME,
    parameter int                  RSP_SHUTDOWN    = DEF_RSP_SHUTDOWN,
    parameter int                  VERSION         = 2,
    parameter int                  NINFO           = 2,
    parameter logic [NINFO*32-1:0] INFO_WORDS      = '0,
    parameter int                  NFAULT          = 8,
    parameter int                  SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         systime,
    input  logic [31:0]         arg_data,
    output logic                arg_advance,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic                cmd_ready,
    output logic                cmd_done,
    output logic [31:0]         param_data,
    output logic                param_write,
    output logic                invol_req,
    input  logic                invol_grant,
    input  logic [63:0]         time_in,
    output logic [63:0]         time_out,
    output logic                time_out_en,
    input  logic                timesync_latch_in,
    output logic                shutdown,
    input  logic [NFAULT-1:0]   fault_in
);

    localparam int               IDX_W   = $clog2(NINFO + 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_info_idx;
    logic [31:0]        r_arg_lo;
    logic [31:0]        r_time_hi;
    logic [63:0]        r_latched_time;
    logic [NFAULT-1:0]  r_fault_vec;
    logic               r_reported;

    logic               w_fall;
    logic               w_fault_pending;
    logic               w_is_ver, w_is_sync, w_is_time, w_is_shut, w_is_clr;

    logic [31:0]        w_param_data;
    logic               w_param_write, w_cmd_done, w_invol_req, w_time_out_en;
    logic [63:0]        w_time_out;
    logic               w_set_shut, w_clr_fault, w_set_rep;
    logic               w_cap_lo, w_cap_hi, w_idx_clr, w_idx_inc;

    assign arg_advance = 1'b1;

    sync_falling_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (timesync_latch_in),
        .o_fall  (w_fall)
    );

    // A fault arriving this very cycle already wins over a simultaneous command.
    assign w_fault_pending = ((r_fault_vec | fault_in) != '0) && !r_reported && !shutdown;

    assign w_is_ver  = cmd_ready && (cmd == CMD_BITS'(CMD_GET_VERSION));
    assign w_is_sync = cmd_ready && (cmd == CMD_BITS'(CMD_SYNC_TIME));
    assign w_is_time = cmd_ready && (cmd == CMD_BITS'(CMD_GET_TIME));
    assign w_is_shut = cmd_ready && (cmd == CMD_BITS'(CMD_SHUTDOWN));
    assign w_is_clr  = cmd_ready && (cmd == CMD_BITS'(CMD_CLEAR_FAULT));

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            cmd_done    <= 1'b0;
            param_data  <= '0;
            param_write <= 1'b0;
            invol_req   <= 1'b0;
            time_out    <= '0;
            time_out_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            cmd_done    <= w_cmd_done;
            param_data  <= w_param_data;
            param_write <= w_param_write;
            invol_req   <= w_invol_req;
            time_out    <= w_time_out;
            time_out_en <= w_time_out_en;
        end
    end

    // Datapath and sticky status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_info_idx     <= '0;
            r_arg_lo       <= '0;
            r_time_hi      <= '0;
            r_latched_time <= '0;
            r_fault_vec    <= '0;
            r_reported     <= 1'b0;
            shutdown       <= 1'b0;
        end else begin
            if (w_idx_clr)      r_info_idx <= '0;
            else if (w_idx_inc) r_info_idx <= r_info_idx + IDX_ONE;
            if (w_cap_lo)       r_arg_lo   <= arg_data;
            if (w_cap_hi)       r_time_hi  <= time_in[63:32];
            if (w_fall)         r_latched_time <= time_in;
            // A live fault survives the clear so it gets reported again.
            if (w_clr_fault) begin
                r_fault_vec <= fault_in;
                r_reported  <= 1'b0;
                shutdown    <= 1'b0;
            end else begin
                r_fault_vec <= r_fault_vec | fault_in;
                if (w_set_rep)  r_reported <= 1'b1;
                if (w_set_shut) shutdown   <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fault_pending) w_state_nxt = ST_WAIT_GRANT;
                else if (w_is_ver)   w_state_nxt = ST_VER;
                else if (w_is_sync)  w_state_nxt = ST_SYNC;
                else if (w_is_time)  w_state_nxt = ST_TIME_HI;
            end
            ST_VER:        if (int'(r_info_idx) >= NINFO) w_state_nxt = ST_IDLE;
            ST_SYNC:       w_state_nxt = ST_IDLE;
            ST_TIME_HI:    w_state_nxt = ST_TIME_RSP;
            ST_TIME_RSP:   w_state_nxt = ST_IDLE;
            ST_WAIT_GRANT: if (invol_grant) w_state_nxt = ST_SHUT_TIME;
            ST_SHUT_TIME:  w_state_nxt = ST_SHUT_RSP;
            ST_SHUT_RSP:   w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath-control logic
    always_comb begin
        w_param_data  = '0;
        w_param_write = 1'b0;
        w_cmd_done    = 1'b0;
        w_invol_req   = 1'b0;
        w_time_out    = time_out;
        w_time_out_en = 1'b0;
        w_set_shut    = 1'b0;
        w_clr_fault   = 1'b0;
        w_set_rep     = 1'b0;
        w_cap_lo      = 1'b0;
        w_cap_hi      = 1'b0;
        w_idx_clr     = 1'b0;
        w_idx_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fault_pending) begin
                    w_invol_req = 1'b1;
                end else if (w_is_ver) begin
                    w_param_data  = 32'(VERSION);
                    w_param_write = 1'b1;
                    w_idx_clr     = 1'b1;
                end else if (w_is_sync) begin
                    w_cap_lo = 1'b1;
                end else if (w_is_time) begin
                    w_param_data  = time_in[31:0];
                    w_param_write = 1'b1;
                    w_cap_hi      = 1'b1;
                end else if (w_is_shut) begin
                    w_set_shut = 1'b1;
                    w_cmd_done = 1'b1;
                end else if (w_is_clr) begin
                    w_clr_fault = 1'b1;
                    w_cmd_done  = 1'b1;
                end
            end
            ST_VER: begin
                if (int'(r_info_idx) < NINFO) begin
                    w_param_data  = INFO_WORDS[32*int'(r_info_idx) +: 32];
                    w_param_write = 1'b1;
                    w_idx_inc     = 1'b1;
                end else begin
                    w_param_data = 32'(RSP_GET_VERSION);
                    w_cmd_done   = 1'b1;
                end
            end
            ST_SYNC: begin
                // Latency of the synchroniser and edge detect is compensated here.
                w_time_out    = time_in - r_latched_time + {arg_data, r_arg_lo}
                              + 64'(SYNC_STAGES) + 64'd2;
                w_time_out_en = 1'b1;
                w_cmd_done    = 1'b1;
            end
            ST_TIME_HI: begin
                w_param_data  = r_time_hi;
                w_param_write = 1'b1;
            end
            ST_TIME_RSP: begin
                w_param_data = 32'(RSP_GET_TIME);
                w_cmd_done   = 1'b1;
            end
            ST_WAIT_GRANT: begin
                if (invol_grant) begin
                    w_param_data  = 32'(r_fault_vec);
                    w_param_write = 1'b1;
                end else begin
                    w_invol_req = 1'b1;
                end
            end
            ST_SHUT_TIME: begin
                w_param_data  = systime;
                w_param_write = 1'b1;
            end
            ST_SHUT_RSP: begin
                w_param_data = 32'(RSP_SHUTDOWN);
                w_cmd_done   = 1'b1;
                w_set_shut   = 1'b1;
                w_set_rep    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_system_ctrl.sv
module tb_system_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] systime;
    logic [31:0] arg_data;
    logic        arg_advance;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic        cmd_done;
    logic [31:0] param_data;
    logic        param_write;
    logic        invol_req;
    logic        invol_grant;
    logic [63:0] time_in;
    logic [63:0] time_out;
    logic        time_out_en;
    logic        timesync_latch_in;
    logic        shutdown;
    logic [7:0]  fault_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    system_ctrl #(
        .NINFO       (2),
        .INFO_WORDS  ({32'h0000_0010, 32'h0403_0201}),
        .NFAULT      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .systime           (systime),
        .arg_data          (arg_data),
        .arg_advance       (arg_advance),
        .cmd               (cmd),
        .cmd_ready         (cmd_ready),
        .cmd_done          (cmd_done),
        .param_data        (param_data),
        .param_write       (param_write),
        .invol_req         (invol_req),
        .invol_grant       (invol_grant),
        .time_in           (time_in),
        .time_out          (time_out),
        .time_out_en       (time_out_en),
        .timesync_latch_in (timesync_latch_in),
        .shutdown          (shutdown),
        .fault_in          (fault_in)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the response stream word, write flag and done flag together.
    task automatic chk_rsp(input string tag, input logic [31:0] d, input logic w, input logic dn);
        chk({tag, ".data"}, 64'(param_data), 64'(d));
        chk({tag, ".write"}, 64'(param_write), 64'(w));
        chk({tag, ".done"}, 64'(cmd_done), 64'(dn));
    endtask

    initial begin
        rst = 1'b1; systime = 32'hCAFE_0001; arg_data = '0; cmd = '0; cmd_ready = 1'b0;
        invol_grant = 1'b0; time_in = '0; timesync_latch_in = 1'b0; fault_in = '0;
        tick(); tick();
        chk("rst.write", 64'(param_write), 64'd0);
        chk("rst.done", 64'(cmd_done), 64'd0);
        chk("rst.invol", 64'(invol_req), 64'd0);
        chk("rst.shutdown", 64'(shutdown), 64'd0);
        chk("rst.ten", 64'(time_out_en), 64'd0);
        chk("rst.arg_adv", 64'(arg_advance), 64'd1);
        rst = 1'b0;
        tick();

        // GET_VERSION
        cmd = 8'd0; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk_rsp("ver0", 32'd2, 1'b1, 1'b0);
        tick(); chk_rsp("ver1", 32'h0403_0201, 1'b1, 1'b0);
        tick(); chk_rsp("ver2", 32'h0000_0010, 1'b1, 1'b0);
        tick(); chk_rsp("ver_rsp", 32'd0, 1'b0, 1'b1);
        tick(); chk("ver.done_pulse", 64'(cmd_done), 64'd0);

        // Unknown command is ignored
        cmd = 8'd7; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk_rsp("unk", 32'd0, 1'b0, 1'b0);
        tick();

        // SYNC_TIME: latch falls while time_in=1000
        time_in = 64'd1000; timesync_latch_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        timesync_latch_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        time_in = 64'd1500;
        cmd = 8'd1; cmd_ready = 1'b1; arg_data = 32'h10;
        tick(); cmd_ready = 1'b0; arg_data = 32'h0;
        chk("sync.ten_early", 64'(time_out_en), 64'd0);
        tick();
        chk("sync.ten", 64'(time_out_en), 64'd1);
        chk("sync.done", 64'(cmd_done), 64'd1);
        chk("sync.time_out", time_out, 64'd520);
        tick();
        chk("sync.ten_pulse", 64'(time_out_en), 64'd0);
        chk("sync.done_pulse", 64'(cmd_done), 64'd0);

        // GET_TIME
        time_in = 64'h0000_0005_0000_0007;
        cmd = 8'd2; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk_rsp("time_lo", 32'd7, 1'b1, 1'b0);
        tick(); chk_rsp("time_hi", 32'd5, 1'b1, 1'b0);
        tick(); chk_rsp("time_rsp", 32'd1, 1'b0, 1'b1);
        tick();

        // Fault report: fault_in[3] one-cycle pulse, grant after 5 cycles
        fault_in = 8'h08;
        tick(); fault_in = 8'h00;
        chk("flt.req", 64'(invol_req), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("flt.req_held", 64'(invol_req), 64'd1);
        chk("flt.no_write", 64'(param_write), 64'd0);
        invol_grant = 1'b1;
        tick(); invol_grant = 1'b0;
        chk("flt.req_drop", 64'(invol_req), 64'd0);
        chk_rsp("flt.vec", 32'h8, 1'b1, 1'b0);
        tick(); chk_rsp("flt.systime", 32'hCAFE_0001, 1'b1, 1'b0);
        tick(); chk_rsp("flt.rsp", 32'd2, 1'b0, 1'b1);
        chk("flt.shutdown", 64'(shutdown), 64'd1);
        fault_in = 8'h40;
        tick(); fault_in = 8'h00;
        tick(); tick();
        chk("flt.second_no_req", 64'(invol_req), 64'd0);
        chk("flt.still_shut", 64'(shutdown), 64'd1);

        // CLEAR_FAULT with fault_in[0] held
        fault_in = 8'h01; cmd = 8'd4; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk("clr1.done", 64'(cmd_done), 64'd1);
        chk("clr1.shutdown", 64'(shutdown), 64'd0);
        tick(); fault_in = 8'h00;
        chk("clr1.req", 64'(invol_req), 64'd1);
        invol_grant = 1'b1;
        tick(); invol_grant = 1'b0;
        chk_rsp("clr1.vec", 32'h1, 1'b1, 1'b0);
        tick(); tick();
        chk_rsp("clr1.rsp", 32'd2, 1'b0, 1'b1);
        chk("clr1.shut_again", 64'(shutdown), 64'd1);

        // CLEAR_FAULT with fault_in low
        cmd = 8'd4; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk("clr2.done", 64'(cmd_done), 64'd1);
        tick(); tick();
        chk("clr2.shutdown", 64'(shutdown), 64'd0);
        chk("clr2.no_req", 64'(invol_req), 64'd0);

        // Priority: fault and GET_TIME together; report first
        time_in = 64'h0000_0009_0000_0003;
        fault_in = 8'h02; cmd = 8'd2; cmd_ready = 1'b1;
        tick(); fault_in = 8'h00;
        chk("pri.req", 64'(invol_req), 64'd1);
        chk("pri.no_write", 64'(param_write), 64'd0);
        invol_grant = 1'b1;
        tick(); invol_grant = 1'b0;
        chk_rsp("pri.vec", 32'h2, 1'b1, 1'b0);
        tick(); tick();
        chk_rsp("pri.rsp", 32'd2, 1'b0, 1'b1);
        tick(); cmd_ready = 1'b0;
        chk_rsp("pri.time_lo", 32'd3, 1'b1, 1'b0);
        tick(); chk_rsp("pri.time_hi", 32'd9, 1'b1, 1'b0);
        tick(); chk_rsp("pri.time_rsp", 32'd1, 1'b0, 1'b1);
        tick();

        // Reset mid GET_VERSION
        cmd = 8'd0; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        tick(); chk_rsp("rv.word0", 32'h0403_0201, 1'b1, 1'b0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_rsp("rv.aborted", 32'd0, 1'b0, 1'b0);
        chk("rv.shut_clear", 64'(shutdown), 64'd0);
        tick(); chk("rv.no_done", 64'(cmd_done), 64'd0);
        cmd = 8'd2; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk_rsp("rv.fresh_lo", 32'd3, 1'b1, 1'b0);
        tick(); tick();
        chk_rsp("rv.fresh_rsp", 32'd1, 1'b0, 1'b1);

        // SHUTDOWN command
        tick();
        cmd = 8'd3; cmd_ready = 1'b1;
        tick(); cmd_ready = 1'b0;
        chk("shut.done", 64'(cmd_done), 64'd1);
        chk("shut.flag", 64'(shutdown), 64'd1);
        chk("shut.no_write", 64'(param_write), 64'd0);
        tick();
        chk("shut.done_pulse", 64'(cmd_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
